// File: rtl/waveform_capture_pkg.sv
// Shared definitions for the waveform capture sink: FSM encoding, geometry
// and the default alternating pattern also used by the generator side.
package waveform_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int BYTE_BITS = 8;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;

  localparam logic [BYTE_BITS-1:0] PAT_EVEN_DEFAULT = 8'hCC;
  localparam logic [BYTE_BITS-1:0] PAT_ODD_DEFAULT  = 8'hAA;

endpackage

// File: rtl/waveform_capture_mem.sv
// 16x8 capture memory: synchronous write, registered read (read-before-write
// on an address collision), synchronous clear of every cell and the read port.
module capture_mem
  import waveform_capture_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BYTE_BITS-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [BYTE_BITS-1:0] rd_data
);

  logic [BYTE_BITS-1:0] mem [DEPTH];

  // Write port and registered read; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (we) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/waveform_capture.sv
// Serial-to-parallel sink for the pattern generator's waveform: assembles
// LSB-first bytes, stores them at an auto-incrementing address and counts
// bytes that differ from the expected alternating pattern.
module waveform_capture
  import waveform_capture_pkg::*;
#(
  parameter logic [BYTE_BITS-1:0] PAT_EVEN = PAT_EVEN_DEFAULT,
  parameter logic [BYTE_BITS-1:0] PAT_ODD  = PAT_ODD_DEFAULT,
  parameter bit                   WRAP     = 1'b0
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 serial_in,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [BYTE_BITS-1:0] rd_data,
  output logic [BYTE_BITS-1:0] byte_data,
  output logic [ADDR_W-1:0]    byte_addr,
  output logic                 byte_valid,
  output logic                 busy,
  output logic                 full,
  output logic [4:0]           mismatch_count
);

  state_t               state_reg;
  logic [2:0]           bit_cnt_reg;
  logic [ADDR_W-1:0]    wr_addr_reg;
  logic [6:0]           shift_reg;
  logic [BYTE_BITS-1:0] byte_data_reg;
  logic [ADDR_W-1:0]    byte_addr_reg;
  logic                 byte_valid_reg;
  logic [4:0]           mismatch_count_reg;

  logic                 sample;
  logic                 byte_done;
  logic [BYTE_BITS-1:0] assembled;
  logic [BYTE_BITS-1:0] expected;

  // A start in any state takes priority over sampling the serial bit.
  assign sample    = (state_reg == CAPTURE) && !start && in_valid;
  assign byte_done = sample && (bit_cnt_reg == 3'd7);
  assign assembled = {serial_in, shift_reg};
  assign expected  = wr_addr_reg[0] ? PAT_ODD : PAT_EVEN;

  // Only bits 0..6 need storage; bit 7 arrives live with serial_in.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_shift
      // Capture serial_in into this bit slot when the bit counter points here.
      always_ff @(posedge clk) begin
        if (clear || start) begin
          shift_reg[gi] <= 1'b0;
        end else if (sample && (bit_cnt_reg == 3'(gi))) begin
          shift_reg[gi] <= serial_in;
        end
      end
    end
  endgenerate

  // Frame FSM, bit/address counters, byte outputs and pattern compare.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg          <= IDLE;
      bit_cnt_reg        <= '0;
      wr_addr_reg        <= '0;
      byte_data_reg      <= '0;
      byte_addr_reg      <= '0;
      byte_valid_reg     <= 1'b0;
      mismatch_count_reg <= '0;
    end else begin
      byte_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg          <= CAPTURE;
            bit_cnt_reg        <= '0;
            wr_addr_reg        <= '0;
            mismatch_count_reg <= '0;
          end
        end
        CAPTURE: begin
          if (start) begin
            bit_cnt_reg        <= '0;
            wr_addr_reg        <= '0;
            mismatch_count_reg <= '0;
          end else if (in_valid) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (byte_done) begin
              byte_data_reg  <= assembled;
              byte_addr_reg  <= wr_addr_reg;
              byte_valid_reg <= 1'b1;
              wr_addr_reg    <= wr_addr_reg + 1'b1;
              if ((assembled != expected) && (mismatch_count_reg < 5'd16)) begin
                mismatch_count_reg <= mismatch_count_reg + 5'd1;
              end
              if ((wr_addr_reg == 4'hF) && !WRAP) begin
                state_reg <= DONE;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  capture_mem u_mem (
    .clk     (clk),
    .clear   (clear),
    .we      (byte_done),
    .wr_addr (wr_addr_reg),
    .wr_data (assembled),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign byte_data      = byte_data_reg;
  assign byte_addr      = byte_addr_reg;
  assign byte_valid     = byte_valid_reg;
  assign busy           = (state_reg == CAPTURE);
  assign full           = (state_reg == DONE);
  assign mismatch_count = mismatch_count_reg;

endmodule
